// File: rtl/axi_mem_port_ctrl_pkg.sv
// axi_mem_port_ctrl_pkg: response codes, FSM state encoding and helpers shared by the
// AXI4-Lite host-port controller for the data memory.
package axi_mem_port_ctrl_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_MEM,
        ST_RD_MEM,
        ST_RD_WAIT,
        ST_WR_RESP,
        ST_RD_RESP
    } state_t;
    function automatic logic [1:0] resp_for(input logic oor);
        return oor ? RESP_SLVERR : RESP_OKAY;
    endfunction
endpackage

// File: rtl/axi_mem_port_ctrl_hold_reg.sv
// axi_mem_port_ctrl_hold_reg: one-entry valid/ready holding register; accepts while empty
// and stays full until the owning transaction's response handshake clears it.
module axi_mem_port_ctrl_hold_reg #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_clr,
    output logic         o_full,
    output logic [W-1:0] o_data
);
    logic         r_full;
    logic [W-1:0] r_data;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end
    end
    assign o_ready = ~r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;
endmodule

// File: rtl/axi_mem_port_ctrl.sv
// axi_mem_port_ctrl: AXI4-Lite slave driving the byte-wide host port of data_mem_unit,
// serialising one read or write at a time with alternating write/read priority.
module axi_mem_port_ctrl
    import axi_mem_port_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int MEM_BYTES_LG = 15,
    parameter int RD_LATENCY   = 1
) (
    input  logic              axi_clk,
    input  logic              axi_rst_n,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [63:0]       mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout
);
    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

    state_t            r_state, w_state_nxt;
    logic              r_prio_wr;
    logic [63:0]       r_mem_addr;
    logic [7:0]        r_mem_din, r_rdata;
    logic [1:0]        r_bresp, r_rresp, r_wait;
    logic              w_aw_full, w_w_full, w_ar_full;
    logic [ADDR_W-1:0] w_awaddr, w_araddr;
    logic [8:0]        w_wbuf;
    logic              w_b_done, w_r_done, w_wr_oor, w_rd_oor;
    logic              w_grant_wr, w_grant_rd, w_rd_last, w_unused;

    assign w_unused = &{1'b0, s_axi_wdata[31:8], s_axi_wstrb[3:1]};
    assign w_b_done = s_axi_bvalid && s_axi_bready;
    assign w_r_done = s_axi_rvalid && s_axi_rready;

    axi_mem_port_ctrl_hold_reg #(.W(ADDR_W)) u_aw (
        .i_clk(axi_clk), .i_rst_n(axi_rst_n), .i_data(s_axi_awaddr), .i_valid(s_axi_awvalid),
        .o_ready(s_axi_awready), .i_clr(w_b_done), .o_full(w_aw_full), .o_data(w_awaddr)
    );
    axi_mem_port_ctrl_hold_reg #(.W(9)) u_w (
        .i_clk(axi_clk), .i_rst_n(axi_rst_n), .i_data({s_axi_wstrb[0], s_axi_wdata[7:0]}),
        .i_valid(s_axi_wvalid), .o_ready(s_axi_wready), .i_clr(w_b_done), .o_full(w_w_full),
        .o_data(w_wbuf)
    );
    axi_mem_port_ctrl_hold_reg #(.W(ADDR_W)) u_ar (
        .i_clk(axi_clk), .i_rst_n(axi_rst_n), .i_data(s_axi_araddr), .i_valid(s_axi_arvalid),
        .o_ready(s_axi_arready), .i_clr(w_r_done), .o_full(w_ar_full), .o_data(w_araddr)
    );

    // Any address bit above the memory's word-index range makes the access an error.
    assign w_wr_oor   = |w_awaddr[ADDR_W-1:MEM_BYTES_LG+2];
    assign w_rd_oor   = |w_araddr[ADDR_W-1:MEM_BYTES_LG+2];
    assign w_grant_wr = (r_state == ST_IDLE) && w_aw_full && w_w_full && (r_prio_wr || !w_ar_full);
    assign w_grant_rd = (r_state == ST_IDLE) && w_ar_full && !w_grant_wr;
    assign w_rd_last  = (r_wait == LAT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:    w_state_nxt = w_grant_wr ? ((w_wr_oor || !w_wbuf[8]) ? ST_WR_RESP : ST_WR_MEM)
                                    : w_grant_rd ? (w_rd_oor ? ST_RD_RESP : ST_RD_MEM) : ST_IDLE;
            ST_WR_MEM:  w_state_nxt = ST_WR_RESP;
            ST_RD_MEM:  w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: w_state_nxt = w_rd_last ? ST_RD_RESP : ST_RD_WAIT;
            ST_WR_RESP: w_state_nxt = s_axi_bready ? ST_IDLE : ST_WR_RESP;
            ST_RD_RESP: w_state_nxt = s_axi_rready ? ST_IDLE : ST_RD_RESP;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            r_state    <= ST_IDLE;
            r_prio_wr  <= 1'b1;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_bresp    <= RESP_OKAY;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
            r_wait     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= (r_state == ST_RD_WAIT) ? r_wait + 2'd1 : 2'd0;
            if (w_grant_wr) begin
                r_prio_wr  <= 1'b0;
                r_mem_addr <= 64'(w_awaddr);
                r_mem_din  <= w_wbuf[7:0];
                r_bresp    <= resp_for(w_wr_oor);
            end
            if (w_grant_rd) begin
                r_prio_wr  <= 1'b1;
                r_mem_addr <= 64'(w_araddr);
                r_rresp    <= resp_for(w_rd_oor);
                r_rdata    <= '0;
            end
            if (r_state == ST_RD_WAIT && w_rd_last)
                r_rdata <= mem_dout;
        end
    end

    assign mem_en       = (r_state == ST_WR_MEM) || (r_state == ST_RD_MEM);
    assign mem_we       = (r_state == ST_WR_MEM);
    assign mem_addr     = r_mem_addr;
    assign mem_din      = r_mem_din;
    assign s_axi_bvalid = (r_state == ST_WR_RESP);
    assign s_axi_bresp  = r_bresp;
    assign s_axi_rvalid = (r_state == ST_RD_RESP);
    assign s_axi_rresp  = r_rresp;
    assign s_axi_rdata  = {24'b0, r_rdata};
endmodule

// File: tb/tb_axi_mem_port_ctrl.sv
// tb_axi_mem_port_ctrl: directed and randomized AXI4-Lite traffic against a byte-memory
// reference model, with a behavioural one-cycle-latency BRAM on the memory port.
module tb_axi_mem_port_ctrl;
    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        mem_en, mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_din, mem_dout;

    int          checks = 0, errors = 0;
    logic [7:0]  bram [0:32767];
    logic [7:0]  ref_mem [int];
    logic        m_prio_wr;
    int          en_cnt = 0, we_cnt = 0;
    logic [63:0] last_we_addr;
    logic [7:0]  last_we_din;

    always #5 clk = ~clk;

    axi_mem_port_ctrl dut (
        .axi_clk(clk), .axi_rst_n(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) bram[mem_addr[16:2]] <= mem_din;
            else mem_dout <= bram[mem_addr[16:2]];
        end

    always @(negedge clk)
        if (mem_en) begin
            en_cnt++;
            if (mem_we) begin
                we_cnt++;
                last_we_addr = mem_addr;
                last_we_din  = mem_din;
            end
        end

    function automatic logic m_oor(input logic [31:0] a);
        return (a >> 17) != 0;
    endfunction

    function automatic logic [7:0] m_read(input logic [31:0] a);
        int i = int'(a >> 2);
        return ref_mem.exists(i) ? ref_mem[i] : 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int lat);
        logic ha, hw;
        int t = 0;
        awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
        while ((awvalid || wvalid) && t < 50) begin
            ha = awvalid && awready;
            hw = wvalid && wready;
            tick();
            if (ha) awvalid = 0;
            if (hw) wvalid = 0;
            t++;
        end
        lat = 0;
        while (!bvalid && lat < 50) begin tick(); lat++; end
        resp = bresp;
        bready = 1; tick(); bready = 0;
        if (!m_oor(a) && s[0]) ref_mem[int'(a >> 2)] = d[7:0];
        m_prio_wr = 0;
    endtask

    task automatic axi_read_start(input logic [31:0] a, output int lat);
        int t = 0;
        logic h;
        araddr = a; arvalid = 1;
        while (arvalid && t < 50) begin h = arready; tick(); if (h) arvalid = 0; t++; end
        lat = 0;
        while (!rvalid && lat < 50) begin tick(); lat++; end
    endtask

    task automatic axi_read_end(output logic [31:0] d, output logic [1:0] resp);
        d = rdata; resp = rresp;
        rready = 1; tick(); rready = 0;
        m_prio_wr = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) tick();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, mem_en, mem_we} !== 7'b1110000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 1110000", {awready, wready, arready, bvalid, rvalid, mem_en, mem_we});
        end
        checks++;
        if ({bresp, rresp, rdata, mem_addr, mem_din} !== '0) begin
            errors++;
            $display("FAIL reset_data: bresp=%0h rresp=%0h rdata=%0h addr=%0h din=%0h expected all 0", bresp, rresp, rdata, mem_addr, mem_din);
        end
        rst_n = 1; m_prio_wr = 1;
        tick();
    endtask

    task automatic test_write_basic();
        logic [1:0] resp;
        int lat, e0 = en_cnt, w0 = we_cnt;
        axi_write(32'h10, 32'hFFFF_FFA5, 4'b0001, resp, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        checks++; if (resp !== 2'b00) begin errors++; $display("FAIL wr_bresp: got %b expected 00", resp); end
        checks++; if (en_cnt - e0 !== 1 || we_cnt - w0 !== 1) begin errors++; $display("FAIL wr_pulse: en=%0d we=%0d cycles expected 1/1", en_cnt - e0, we_cnt - w0); end
        checks++; if (last_we_addr !== 64'h10 || last_we_din !== 8'hA5) begin errors++; $display("FAIL wr_port: addr=%0h din=%0h expected 10/a5", last_we_addr, last_we_din); end
    endtask

    task automatic test_read_hold();
        logic [31:0] d, d0;
        logic [1:0]  resp;
        int lat, bad = 0;
        axi_read_start(32'h10, lat);
        checks++; if (lat !== 2 + RD_LAT) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, 2 + RD_LAT); end
        d0 = rdata;
        repeat (5) begin tick(); if (!rvalid || rdata !== d0) bad++; end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rd_stable: %0d unstable cycles expected 0", bad); end
        axi_read_end(d, resp);
        checks++; if (d !== {24'h0, m_read(32'h10)}) begin errors++; $display("FAIL rd_data: got %0h expected %0h", d, m_read(32'h10)); end
        checks++; if (resp !== 2'b00) begin errors++; $display("FAIL rd_rresp: got %b expected 00", resp); end
    endtask

    task automatic test_w_before_aw();
        int e0, lat = 0;
        wdata = 32'h1234_565A; wstrb = 4'b1111; wvalid = 1;
        tick(); wvalid = 0;
        checks++; if (wready !== 1'b0) begin errors++; $display("FAIL wfirst_wready: got %b expected 0", wready); end
        e0 = en_cnt;
        repeat (3) tick();
        awaddr = 32'h44; awvalid = 1;
        tick(); awvalid = 0;
        checks++; if (en_cnt !== e0) begin errors++; $display("FAIL wfirst_early_en: %0d cycles expected 0", en_cnt - e0); end
        while (!bvalid && lat < 50) begin tick(); lat++; end
        checks++; if (lat !== 2) begin errors++; $display("FAIL wfirst_latency: got %0d expected 2", lat); end
        bready = 1; tick(); bready = 0;
        checks++; if (last_we_addr !== 64'h44 || last_we_din !== 8'h5A) begin errors++; $display("FAIL wfirst_port: addr=%0h din=%0h expected 44/5a", last_we_addr, last_we_din); end
        ref_mem[int'(32'h44 >> 2)] = 8'h5A;
        m_prio_wr = 0;
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        logic [1:0]  resp;
        int lat, e0 = en_cnt;
        axi_write(32'h0002_0000, 32'h77, 4'b0001, resp, lat);
        checks++; if (resp !== 2'b10) begin errors++; $display("FAIL oor_bresp: got %b expected 10", resp); end
        axi_read_start(32'h0002_0000, lat);
        axi_read_end(d, resp);
        checks++; if (resp !== 2'b10 || d !== 32'h0) begin errors++; $display("FAIL oor_read: rresp=%b rdata=%0h expected 10/0", resp, d); end
        checks++; if (en_cnt !== e0) begin errors++; $display("FAIL oor_mem_en: %0d cycles expected 0", en_cnt - e0); end
    endtask

    task automatic test_wstrb0();
        logic [1:0] resp;
        int lat, w0 = we_cnt;
        axi_write(32'h30, 32'hFF, 4'b1110, resp, lat);
        checks++; if (resp !== 2'b00 || we_cnt !== w0) begin errors++; $display("FAIL wstrb0: bresp=%b we_cycles=%0d expected 00/0", resp, we_cnt - w0); end
    endtask

    task automatic do_pair(input logic [31:0] aw, input logic [7:0] d, input logic [31:0] ar,
                           output logic first_wr, output logic [31:0] rd,
                           output logic [1:0] br, output logic [1:0] rr);
        logic got_b = 0, got_r = 0;
        int t = 0;
        first_wr = 0; rd = '1; br = '1; rr = '1;
        awaddr = aw; wdata = {24'hABCDEF, d}; wstrb = 4'b0001; araddr = ar;
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        while (!(got_b && got_r) && t < 60) begin
            if (bvalid && !got_b) begin got_b = 1; br = bresp; if (!got_r) first_wr = 1; end
            if (rvalid && !got_r) begin got_r = 1; rd = rdata; rr = rresp; end
            tick(); t++;
        end
        bready = 0; rready = 0;
    endtask

    task automatic test_arbitration();
        logic first_wr, exp_first;
        logic [31:0] rd, aw, exp_rd;
        logic [7:0]  d;
        logic [1:0]  br, rr;
        rst_n = 0; tick(); rst_n = 1; m_prio_wr = 1; tick();
        for (int i = 0; i < 3; i++) begin
            aw = (i == 0) ? 32'h20 : 32'h24 + 32'(i * 4);
            d  = (i == 0) ? 8'h3C : 8'($urandom);
            exp_first = m_prio_wr;
            exp_rd = {24'h0, exp_first ? d : m_read(aw)};
            do_pair(aw, d, aw, first_wr, rd, br, rr);
            ref_mem[int'(aw >> 2)] = d;
            m_prio_wr = exp_first;
            checks++; if (first_wr !== exp_first) begin errors++; $display("FAIL arb_order[%0d]: write_first=%b expected %b", i, first_wr, exp_first); end
            checks++; if (rd !== exp_rd || br !== 2'b00 || rr !== 2'b00) begin errors++; $display("FAIL arb_data[%0d]: rdata=%0h bresp=%b rresp=%b expected %0h/00/00", i, rd, br, rr, exp_rd); end
        end
    endtask

    task automatic test_reset_rd_wait();
        logic [31:0] d;
        logic [1:0]  resp;
        int lat, bad = 0;
        araddr = 32'h10; arvalid = 1;
        tick(); arvalid = 0;
        tick(); tick();
        #2 rst_n = 0;
        #1;
        checks++; if (rvalid !== 1'b0 || mem_en !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL rst_midop: rvalid=%b mem_en=%b arready=%b expected 0/0/1", rvalid, mem_en, arready); end
        tick(); rst_n = 1; m_prio_wr = 1;
        repeat (4) begin tick(); if (rvalid || bvalid) bad++; end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rst_no_resp: %0d response cycles expected 0", bad); end
        axi_read_start(32'h10, lat);
        axi_read_end(d, resp);
        checks++; if (lat !== 2 + RD_LAT || d !== {24'h0, m_read(32'h10)} || resp !== 2'b00) begin errors++; $display("FAIL rst_next_read: lat=%0d rdata=%0h rresp=%b expected %0d/%0h/00", lat, d, resp, 2 + RD_LAT, m_read(32'h10)); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, exp_d;
        logic [3:0]  s;
        logic [1:0]  resp;
        logic        oor;
        int lat, w0, exp_lat;
        for (int i = 0; i < 40; i++) begin
            oor = ($urandom_range(0, 5) == 0);
            a = (oor ? (32'($urandom_range(1, 32767)) << 17) : 32'h0) | 32'($urandom_range(0, 255));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                w0 = we_cnt;
                exp_lat = (oor || !s[0]) ? 1 : 2;
                axi_write(a, d, s, resp, lat);
                checks++;
                if (resp !== (oor ? 2'b10 : 2'b00) || lat !== exp_lat || we_cnt - w0 !== int'(!oor && s[0])) begin
                    errors++;
                    $display("FAIL rnd_write[%0d] a=%0h: bresp=%b lat=%0d we=%0d expected %b/%0d/%0d", i, a, resp, lat, we_cnt - w0, oor ? 2'b10 : 2'b00, exp_lat, int'(!oor && s[0]));
                end
            end else begin
                exp_d = oor ? 32'h0 : {24'h0, m_read(a)};
                exp_lat = oor ? 1 : 2 + RD_LAT;
                axi_read_start(a, lat);
                axi_read_end(d, resp);
                checks++;
                if (d !== exp_d || resp !== (oor ? 2'b10 : 2'b00) || lat !== exp_lat) begin
                    errors++;
                    $display("FAIL rnd_read[%0d] a=%0h: rdata=%0h rresp=%b lat=%0d expected %0h/%b/%0d", i, a, d, resp, lat, exp_d, oor ? 2'b10 : 2'b00, exp_lat);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32768; i++) bram[i] = 8'h00;
        mem_dout = 8'h00;
        awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arvalid = 0; rready = 0;
        test_reset();
        test_write_basic();
        test_read_hold();
        test_w_before_aw();
        test_out_of_range();
        test_wstrb0();
        test_arbitration();
        test_reset_rd_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
